// File: rtl/multi_timer_pkg.sv
// -----------------------------------------------------------------------------
// multi_timer_pkg
// Shared definitions for the multi-channel countdown timer.
//   chan_state_t : per-channel FSM state encoding
//                  (IDLE=0, RUN=1, PAUSE=2, EXPIRED=3)
//   ps_width()   : register width needed for a 0..p-1 prescaler counter
//                  (never less than one bit, so PRESCALE=1 stays legal)
// -----------------------------------------------------------------------------
package multi_timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_PAUSE   = 2'd2,
      ST_EXPIRED = 2'd3
   } chan_state_t;

   function automatic int unsigned ps_width(input int unsigned p);
      return (p > 1) ? $clog2(p) : 1;
   endfunction

endpackage

// File: rtl/timer_channel.sv
// -----------------------------------------------------------------------------
// timer_channel
// One countdown channel: FSM, count register, reload register, mode latch and
// registered done/busy outputs. Advances only on cycles where tick is high.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   tick         : shared prescaler tick (one cycle wide)
//   load         : load strobe for this channel
//   load_val     : value to load (shared bus)
//   en           : run enable; low pauses the channel
//   clear        : abort to IDLE, highest priority
//   reload_mode  : 0 one-shot, 1 auto-reload; latched on load
//   count        : current count (registered)
//   done         : one-cycle expiry pulse (registered)
//   busy         : high while in RUN or PAUSE (registered)
// -----------------------------------------------------------------------------
module timer_channel
   import multi_timer_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             clear,
   input  logic             reload_mode,
   output logic [WIDTH-1:0] count,
   output logic             done,
   output logic             busy
);

   chan_state_t      state;
   logic [WIDTH-1:0] reload_val;
   logic             auto_reload;

   // Priority: clear > load > pause/resume > tick. busy is written alongside
   // every state change so it is a true register mirroring RUN/PAUSE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         count       <= '0;
         reload_val  <= '0;
         auto_reload <= 1'b0;
         done        <= 1'b0;
         busy        <= 1'b0;
      end else begin
         done <= 1'b0;
         if (clear) begin
            state <= ST_IDLE;
            count <= '0;
            busy  <= 1'b0;
         end else if (load) begin
            if (load_val != '0) begin
               count       <= load_val;
               reload_val  <= load_val;
               auto_reload <= reload_mode;
               state       <= en ? ST_RUN : ST_PAUSE;
               busy        <= 1'b1;
            end else begin
               count <= '0;
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         end else begin
            case (state)
               ST_RUN: begin
                  if (!en) begin
                     state <= ST_PAUSE;
                  end else if (tick) begin
                     if (count == WIDTH'(1)) begin
                        done <= 1'b1;
                        if (auto_reload) begin
                           count <= reload_val;
                        end else begin
                           count <= '0;
                           state <= ST_EXPIRED;
                           busy  <= 1'b0;
                        end
                     end else if (count != '0) begin
                        count <= count - WIDTH'(1);
                     end
                  end
               end
               ST_PAUSE: begin
                  if (en) begin
                     state <= ST_RUN;
                  end
               end
               default: begin
                  // IDLE and EXPIRED hold until load or clear
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/multi_timer.sv
// -----------------------------------------------------------------------------
// multi_timer
// CHANNELS independent countdown timers sharing one free-running prescaler.
// Parameters:
//   WIDTH    : bits per channel count / load value
//   CHANNELS : number of channels (>=1)
//   PRESCALE : clk cycles per count tick (>=1)
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   load         : per-channel load strobe
//   load_val     : shared load value
//   en           : per-channel run enable
//   clear        : per-channel abort to IDLE
//   reload_mode  : per-channel mode (0 one-shot, 1 auto-reload)
//   count        : channel i at [i*WIDTH +: WIDTH]
//   done         : per-channel one-cycle expiry pulse
//   busy         : per-channel RUN/PAUSE indicator
// -----------------------------------------------------------------------------
module multi_timer
   import multi_timer_pkg::*;
#(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned CHANNELS = 2,
   parameter int unsigned PRESCALE = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS-1:0]       load,
   input  logic [WIDTH-1:0]          load_val,
   input  logic [CHANNELS-1:0]       en,
   input  logic [CHANNELS-1:0]       clear,
   input  logic [CHANNELS-1:0]       reload_mode,
   output logic [CHANNELS*WIDTH-1:0] count,
   output logic [CHANNELS-1:0]       done,
   output logic [CHANNELS-1:0]       busy
);

   localparam int unsigned PW = ps_width(PRESCALE);

   logic [PW-1:0] ps_cnt;
   logic          tick;

   // With PRESCALE=1 the counter is stuck at 0 and tick is permanently high.
   always_comb begin
      tick = (ps_cnt == PW'(PRESCALE - 1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ps_cnt <= '0;
      end else if (tick) begin
         ps_cnt <= '0;
      end else begin
         ps_cnt <= ps_cnt + PW'(1);
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      timer_channel #(
         .WIDTH (WIDTH)
      ) u_chan (
         .clk         (clk),
         .rst         (rst),
         .tick        (tick),
         .load        (load[i]),
         .load_val    (load_val),
         .en          (en[i]),
         .clear       (clear[i]),
         .reload_mode (reload_mode[i]),
         .count       (count[i*WIDTH +: WIDTH]),
         .done        (done[i]),
         .busy        (busy[i])
      );
   end

endmodule

// File: tb/tb_multi_timer.sv
// -----------------------------------------------------------------------------
// tb_multi_timer
// Two multi_timer instances (PRESCALE=1 and PRESCALE=4) driven by the same
// inputs and compared every cycle against a behavioural model, plus directed
// scenarios with fixed expectations.
// -----------------------------------------------------------------------------
module tb_multi_timer;

   localparam int W     = 8;
   localparam int C     = 2;
   localparam int PRE_B = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [C-1:0]   load, en, clear, reload_mode;
   logic [W-1:0]   load_val;
   logic [C*W-1:0] count_a, count_b;
   logic [C-1:0]   done_a, done_b, busy_a, busy_b;

   always #5 clk = ~clk;

   multi_timer #(.WIDTH(W), .CHANNELS(C), .PRESCALE(1)) dut_a (
      .clk(clk), .rst(rst), .load(load), .load_val(load_val), .en(en),
      .clear(clear), .reload_mode(reload_mode),
      .count(count_a), .done(done_a), .busy(busy_a));

   multi_timer #(.WIDTH(W), .CHANNELS(C), .PRESCALE(PRE_B)) dut_b (
      .clk(clk), .rst(rst), .load(load), .load_val(load_val), .en(en),
      .clear(clear), .reload_mode(reload_mode),
      .count(count_b), .done(done_b), .busy(busy_b));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Each channel is "live" (busy) or not; a live channel is either paused or
   // counting. Ticks occur at edge k (counted from reset release) when
   // k mod P == P-1.
   int pre [2] = '{1, PRE_B};
   int edges;
   int m_cnt    [2][C];
   int m_rel    [2][C];
   bit m_auto   [2][C];
   bit m_live   [2][C];
   bit m_paused [2][C];
   bit m_done   [2][C];

   task automatic model_reset();
      edges = 0;
      for (int d = 0; d < 2; d++)
         for (int c = 0; c < C; c++) begin
            m_cnt[d][c] = 0; m_rel[d][c] = 0; m_auto[d][c] = 0;
            m_live[d][c] = 0; m_paused[d][c] = 0; m_done[d][c] = 0;
         end
   endtask

   task automatic model_edge();
      bit tk;
      for (int d = 0; d < 2; d++) begin
         tk = ((edges % pre[d]) == pre[d] - 1);
         for (int c = 0; c < C; c++) begin
            m_done[d][c] = 0;
            if (clear[c]) begin
               m_cnt[d][c] = 0; m_live[d][c] = 0;
            end else if (load[c]) begin
               if (load_val != 0) begin
                  m_cnt[d][c] = int'(load_val); m_rel[d][c] = int'(load_val);
                  m_auto[d][c] = reload_mode[c]; m_live[d][c] = 1;
                  m_paused[d][c] = !en[c];
               end else begin
                  m_cnt[d][c] = 0; m_live[d][c] = 0;
               end
            end else if (m_live[d][c]) begin
               if (m_paused[d][c]) begin
                  if (en[c]) m_paused[d][c] = 0;
               end else if (!en[c]) begin
                  m_paused[d][c] = 1;
               end else if (tk) begin
                  if (m_cnt[d][c] == 1) begin
                     m_done[d][c] = 1;
                     if (m_auto[d][c]) m_cnt[d][c] = m_rel[d][c];
                     else begin m_cnt[d][c] = 0; m_live[d][c] = 0; end
                  end else begin
                     m_cnt[d][c] = m_cnt[d][c] - 1;
                  end
               end
            end
         end
      end
      edges++;
   endtask

   task automatic check_outputs(input string tag);
      for (int c = 0; c < C; c++) begin
         chk($sformatf("%s a.count[%0d]", tag, c), count_a[c*W +: W], m_cnt[0][c]);
         chk($sformatf("%s a.done[%0d]",  tag, c), done_a[c],  m_done[0][c]);
         chk($sformatf("%s a.busy[%0d]",  tag, c), busy_a[c],  m_live[0][c]);
         chk($sformatf("%s b.count[%0d]", tag, c), count_b[c*W +: W], m_cnt[1][c]);
         chk($sformatf("%s b.done[%0d]",  tag, c), done_b[c],  m_done[1][c]);
         chk($sformatf("%s b.busy[%0d]",  tag, c), busy_b[c],  m_live[1][c]);
      end
   endtask

   // Inputs are changed only at negedge; step samples #1 after posedge.
   task automatic step(input string tag);
      @(posedge clk);
      #1;
      model_edge();
      check_outputs(tag);
      @(negedge clk);
   endtask

   task automatic clear_all();
      load = '0; clear = '1;
      step("clr");
      clear = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      int pulses;
      int n;
      bit seen;
      int seq2 [6] = '{1, 2, 1, 2, 1, 2};

      rst = 1'b1; load = '0; clear = '0; en = '0; reload_mode = '0; load_val = '0;
      #1;
      chk("reset count_a", count_a, 0);
      chk("reset busy_a",  busy_a,  0);
      chk("reset done_b",  done_b,  0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      model_reset();

      // one-shot ch0 load 3
      en = 2'b11; reload_mode = 2'b00; load_val = 8'd3; load = 2'b01;
      step("t032");
      load = '0;
      chk("t032 count=3", count_a[7:0], 3);
      for (int i = 2; i >= 0; i--) begin
         step("t032");
         chk("t032 count seq", count_a[7:0], i);
      end
      chk("t032 done at 0", done_a[0], 1);
      chk("t032 busy dropped", busy_a[0], 0);
      step("t032");
      chk("t032 done one cycle", done_a[0], 0);
      chk("t032 count holds 0", count_a[7:0], 0);

      // auto-reload ch1 load 2
      clear_all();
      reload_mode = 2'b10; load_val = 8'd2; load = 2'b10;
      step("t033");
      load = '0;
      for (int i = 0; i < 6; i++) begin
         step("t033");
         chk("t033 ch1 count", count_a[15:8], seq2[i]);
         chk("t033 ch1 done", done_a[1], (seq2[i] == 2));
         chk("t033 ch0 idle", count_a[7:0], 0);
      end

      // pause/resume ch0 load 5
      clear_all();
      reload_mode = 2'b00; load_val = 8'd5; load = 2'b01;
      step("t034");
      load = '0;
      step("t034"); step("t034");
      en[0] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step("t034");
         chk("t034 held", count_a[7:0], 3);
      end
      en[0] = 1'b1;
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         step("t034");
         if (done_a[0]) pulses++;
      end
      chk("t034 done once", pulses, 1);
      chk("t034 final count", count_a[7:0], 0);

      // load at expiry, then clear+load
      clear_all();
      load_val = 8'd3; load = 2'b01;
      step("t035");
      load = '0;
      step("t035"); step("t035");
      chk("t035 at 1", count_a[7:0], 1);
      load_val = 8'd7; load = 2'b01;
      step("t035");
      chk("t035 reload 7", count_a[7:0], 7);
      chk("t035 no done", done_a[0], 0);
      clear = 2'b01;
      step("t035");
      clear = '0; load = '0;
      chk("t035 clear wins", count_a[7:0], 0);
      chk("t035 clear busy", busy_a[0], 0);

      // reset mid-count
      clear_all();
      load_val = 8'd6; load = 2'b01;
      step("t036");
      load = '0;
      step("t036"); step("t036");
      chk("t036 at 4", count_a[7:0], 4);
      rst = 1'b1;
      #1;
      chk("t036 rst count", count_a, 0);
      chk("t036 rst busy", busy_a, 0);
      chk("t036 rst done", done_a, 0);
      load = 2'b11; load_val = 8'd9;
      @(posedge clk); @(negedge clk);
      chk("t036 ignore inputs", count_b, 0);
      rst = 1'b0; load = '0;
      model_reset();

      // prescaled load 2 (checked on the PRESCALE=4 instance)
      load_val = 8'd2; load = 2'b01; en = 2'b11; reload_mode = 2'b00;
      step("t037");
      load = '0;
      chk("t037 no done after rst", done_a, 0);
      n = 0; seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         step("t037");
         n++;
         if (done_b[0]) seen = 1;
      end
      chk("t037 done seen", seen, 1);
      chk("t037 done latency 5..8", (n >= 5 && n <= 8), 1);

      // randomized traffic
      for (int i = 0; i < 500; i++) begin
         for (int c = 0; c < C; c++) begin
            load[c]        = ($urandom % 8) == 0;
            clear[c]       = ($urandom % 40) == 0;
            en[c]          = ($urandom % 6) != 0;
            reload_mode[c] = $urandom % 2;
         end
         load_val = (($urandom % 5) == 0) ? 8'd0 : W'($urandom_range(1, 9));
         if (($urandom % 150) == 0) begin
            rst = 1'b1;
            #1;
            model_reset();
            check_outputs("rnd_rst");
            @(negedge clk);
            rst = 1'b0;
         end else begin
            step("rnd");
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
